iterative_alu: RTL

- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder, plus two operands.
- Returns a registered result and a zero flag.
- AND, OR, ADD, SUB and XOR complete in one cycle. SRA is iterative, one bit per cycle, so no barrel shifter is needed.
- Valid/ready handshakes on both the input and output sides let the pipeline stall around multi-cycle shifts.

---
 rtl/iterative_alu.sv | 100 ++++++++++
 1 files changed

// File: rtl/iterative_alu.sv
// Execute-stage ALU: AND/OR/ADD/SUB/XOR finish in one cycle, SRA shifts one bit per cycle.
// Valid/ready on both sides; the result is held in DONE until the consumer takes it.
module iterative_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         aluctrl,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b1111;
  localparam logic [3:0] OP_SRA = 4'b1110;

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0]        cnt_q, cnt_d;
  logic [SHAMT_W-1:0]        shamt;

  // Single-cycle operations; unknown codes produce zero.
  function automatic logic signed [WIDTH-1:0] alu_op(
    input logic [3:0]              ctrl,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    case (ctrl)
      OP_AND:  alu_op = a & b;
      OP_OR:   alu_op = a | b;
      OP_ADD:  alu_op = a + b;
      OP_SUB:  alu_op = a - b;
      OP_XOR:  alu_op = a ^ b;
      OP_SRA:  alu_op = a;
      default: alu_op = '0;
    endcase
  endfunction

  assign shamt = op_b[SHAMT_W-1:0];

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (aluctrl == OP_SRA && shamt != '0) begin
            result_d = op_a;
            cnt_d    = shamt;
            state_d  = SHIFT;
          end else begin
            result_d = alu_op(aluctrl, op_a, op_b);
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        result_d = result_q >>> 1;
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset also clears the result so an abandoned shift never leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule
